alu_exec_stage: RTL
===================

# alu_exec_stage

Registered execute stage between the ALU control unit and the memory stage. It consumes the `alu_sel_e` selection produced by the control unit, plus decoded operands, and performs the ALU operation. Shifts use an iterative one-bit-per-cycle shifter; other operations take one cycle. It resolves branch outcomes and presents a single valid/ready output slot toward the memory stage.

## Interface
- DATA_WIDTH, 32: operand/result width. Must be 32; shift amount is `op_b_i[4:0]`.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  upstream has an operation.
- in_ready_o  out  1  stage accepts the operation this cycle.
- alu_sel_i  in  alu_sel_e  operation select from the control unit.
- op_a_i, op_b_i  in  DATA_WIDTH  operands; op_b is already the immediate for I/S/U types.
- is_branch_i  in  1  operation is a conditional branch.
- funct3_i  in  3  branch condition (RV32I B-type encoding).
- rd_addr_i  in  5  destination register, passed through.
- reg_write_i  in  1  write-back enable, passed through.
- flush_i  in  1  kill the in-flight and held operation (mispredict/trap).
- out_valid_o  out  1  result slot holds a valid operation.
- out_ready_i  in  1  downstream consumes the slot.
- result_o  out  DATA_WIDTH  ALU result.
- br_taken_o  out  1  branch condition true; 0 if not a branch.
- rd_addr_o  out  5  registered rd_addr_i.
- reg_write_o  out  1  registered reg_write_i.

## Operation
- States: IDLE, SHIFT. Output slot is separate: out_valid plus payload registers.
- in_ready_o = !rst_i && !flush_i && state==IDLE && (!out_valid_o || out_ready_i). Accept = in_valid_i && in_ready_o.
- Accept of a non-shift op, or a shift (SLL/SRL/SRA) with shamt==0: the result and payload are written to the slot, out_valid_o=1, and the state stays IDLE.
- Accept of a shift with shamt≠0: shift_reg=op_a_i, cnt=shamt, and rd, reg_write and the shift type are latched. State goes to SHIFT, and out_valid_o clears if the slot was drained.
- SHIFT: each cycle shift_reg shifts 1 bit (SLL left with 0 fill, SRL right with 0 fill, SRA right with sign fill), and cnt decrements. On the edge where cnt==1, the shifted value goes to result_o, out_valid_o=1, br_taken_o=0, and the state returns to IDLE.
- Ops: ADD/SUB use mod-2^32 wraparound. SLT is signed and SLTU unsigned, giving {31'b0,bit}. XOR/OR/AND are bitwise. PASS_B gives op_b. ALU_X gives result 0, still produces a valid output, and forces br_taken 0.
- Branch (is_branch_i=1), using the computed result:
  - 000 → result==0
  - 001 → result!=0
  - 100/110 → result[0]
  - 101/111 → !result[0]
  - 010/011 → 0
- When is_branch_i=0, br_taken_o is 0.
- Backpressure: while out_valid_o && !out_ready_i, all output payload is held stable.
- flush_i (priority over everything except reset): on that edge out_valid_o←0 and state←IDLE, aborting any shift. No accept happens that cycle.
- Reset: state IDLE, out_valid_o=0, result_o=0, br_taken_o=0, rd_addr_o=0, reg_write_o=0, cnt=0.

## Timing
- Non-shift or shamt==0 op: accepted at edge E, out_valid_o high after E (latency 1).
- Full throughput of 1 op/cycle under out_ready_i=1.
- Shift with shamt=k≥1: latency 1+k edges from accept. in_ready_o stays low for those k cycles. Worst case is k=31, for 32 cycles.
- Simultaneous drain and accept in one cycle is legal. The slot is overwritten (non-shift) or cleared (shift start).
- flush_i and in_valid_i in the same cycle: nothing is accepted, and in_ready_o returns the next cycle.
- Reset mid-SHIFT: IDLE next cycle, no output produced.
- in_ready_o is combinational from state, out_valid_o, out_ready_i, flush_i and rst_i. There is no combinational path from in_valid_i to any output.

## Test plan
- ADD 0xFFFFFFFF+1 with out_ready=1 → one cycle later result 0, out_valid 1; a back-to-back SUB 5−7 → 0xFFFFFFFE on the following cycle.
- SRA op_a=0x80000000, shamt=4 → in_ready low 4 cycles, result 0xF8000000 at accept+5. SLL shamt=0 on 0x1234 → 0x1234 at latency 1.
- Branch BLT: SLT with a=−1, b=1, funct3=100 → br_taken 1. BGEU: SLTU with a=1, b=0xFFFFFFFF, funct3=111 → br_taken 0. BEQ: SUB 7−7, funct3=000 → br_taken 1.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and output payload stable. Raise out_ready → the next op is accepted the same cycle.
- SRL shamt=20 started, flush_i pulsed at cycle 3 → out_valid never rises for it, in_ready=1 the next cycle, and a following ADD completes normally.
- rst_i asserted during SHIFT with out_valid=1 → all outputs 0 and in_ready=1 on the cycle after rst_i deasserts.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops, iterative 1-bit/cycle shifter, branch resolution,
// and one valid/ready result slot toward the memory stage.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B, ALU_X
  } alu_sel_e;
endpackage

module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  alu_sel_e              alu_sel_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  input  logic                  is_branch_i,
  input  logic [2:0]            funct3_i,
  input  logic [4:0]            rd_addr_i,
  input  logic                  reg_write_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  br_taken_o,
  output logic [4:0]            rd_addr_o,
  output logic                  reg_write_o
);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [4:0]            rd_q, rd_d;
  alu_sel_e              sh_op_q, sh_op_d;
  logic                  out_valid_q, out_valid_d;
  logic                  br_q, br_d;
  logic                  rw_q, rw_d;

  logic [4:0]            shamt;
  logic                  accept;
  logic                  is_shift;
  logic                  shift_start;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  br_cond;

  assign shamt       = op_b_i[4:0];
  assign accept      = in_valid_i && in_ready_o;
  assign is_shift    = (alu_sel_i == ALU_SLL) || (alu_sel_i == ALU_SRL) || (alu_sel_i == ALU_SRA);
  assign shift_start = accept && is_shift && (shamt != 5'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      sh_op_q     <= ALU_SLL;
      out_valid_q <= 1'b0;
      br_q        <= 1'b0;
      rw_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      sh_op_q     <= sh_op_d;
      out_valid_q <= out_valid_d;
      br_q        <= br_d;
      rw_q        <= rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (shift_start) state_d = S_SHIFT;
        S_SHIFT: if (cnt_q == 5'd1) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (alu_sel_i)
      ALU_ADD:    alu_res = op_a_i + op_b_i;
      ALU_SUB:    alu_res = op_a_i - op_b_i;
      ALU_SLT:    alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
      ALU_SLTU:   alu_res = {{(DATA_WIDTH-1){1'b0}}, op_a_i < op_b_i};
      ALU_XOR:    alu_res = op_a_i ^ op_b_i;
      ALU_OR:     alu_res = op_a_i | op_b_i;
      ALU_AND:    alu_res = op_a_i & op_b_i;
      ALU_PASS_B: alu_res = op_b_i;
      // Only shamt==0 shifts complete here; nonzero amounts go through the iterative path.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a_i;
      default:    alu_res = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    if (is_branch_i && (alu_sel_i != ALU_X)) begin
      case (funct3_i)
        3'b000:          br_cond = (alu_res == '0);
        3'b001:          br_cond = (alu_res != '0);
        3'b100, 3'b110:  br_cond = alu_res[0];
        3'b101, 3'b111:  br_cond = !alu_res[0];
        default:         br_cond = 1'b0;
      endcase
    end
  end

  always_comb begin
    shifted = shift_q;
    case (sh_op_q)
      ALU_SLL: shifted = {shift_q[DATA_WIDTH-2:0], 1'b0};
      ALU_SRL: shifted = {1'b0, shift_q[DATA_WIDTH-1:1]};
      default: shifted = {shift_q[DATA_WIDTH-1], shift_q[DATA_WIDTH-1:1]};
    endcase
  end

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    sh_op_d     = sh_op_q;
    result_d    = result_q;
    br_d        = br_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    if (flush_i) begin
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else if (state_q == S_SHIFT) begin
      shift_d = shifted;
      cnt_d   = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        result_d    = shifted;
        br_d        = 1'b0;
        out_valid_d = 1'b1;
      end
    end else if (accept) begin
      // Slot is empty or draining on any accept, so rd/reg_write can be parked there during a shift.
      rd_d = rd_addr_i;
      rw_d = reg_write_i;
      if (shift_start) begin
        shift_d = op_a_i;
        cnt_d   = shamt;
        sh_op_d = alu_sel_i;
      end else begin
        result_d    = alu_res;
        br_d        = br_cond;
        out_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready_o  = !rst_i && !flush_i && (state_q == S_IDLE) && (!out_valid_q || out_ready_i);
    out_valid_o = out_valid_q;
    result_o    = result_q;
    br_taken_o  = br_q;
    rd_addr_o   = rd_q;
    reg_write_o = rw_q;
  end

endmodule
